// File: rtl/ps2_scancode_rx_if.sv
// Consumer-side bundle of the PS/2 scancode receiver: pop handshake,
// head-of-FIFO data and status flags.
interface ps2_scancode_rx_if #(
  parameter int CNT_W = 4
);
  logic             out_ready;
  logic             ovf_clr;
  logic             out_valid;
  logic [7:0]       out_data;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;
  logic             frame_err;

  // Receiver side: produces the head entry and status.
  modport master (
    input  out_ready, ovf_clr,
    output out_valid, out_data, fifo_count, overflow, frame_err
  );

  // Consumer side: pops entries and clears the overflow flag.
  modport slave (
    output out_ready, ovf_clr,
    input  out_valid, out_data, fifo_count, overflow, frame_err
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises the device clock/data, deserialises
// 11-bit frames (start, 8 data LSB first, odd parity, stop), and buffers good
// scancodes in a small show-ahead FIFO popped with valid/ready.
module ps2_scancode_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_scancode_rx_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  logic [2:0]       ps2c_q;
  logic [1:0]       ps2d_q;
  state_t           state_q;
  logic [3:0]       bit_cnt_q;
  logic [9:0]       shreg_q;
  logic [TMO_W-1:0] tmo_q;
  logic             frame_err_q;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W-1:0] rd_nxt;
  logic [CNT_W-1:0] count_q;
  logic [7:0]       head_q;
  logic             ovf_q;

  logic fall, data_bit, last_edge, frame_ok, push;
  logic pop, full, wr_en, ovf_set;
  logic [7:0] wdata;

  assign fall      = (ps2c_q[2:1] == 2'b10);
  assign data_bit  = ps2d_q[1];
  assign last_edge = (state_q == S_SHIFT) && fall && (bit_cnt_q == 4'd10);
  // shreg_q[0] = start, [8:1] = data, [9] = parity; stop bit is arriving now
  assign frame_ok  = !shreg_q[0] && data_bit && (^shreg_q[9:1]);
  assign push      = last_edge && frame_ok;
  assign wdata     = shreg_q[8:1];

  assign pop     = (count_q != '0) && bus.out_ready;
  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && !wr_en;
  assign rd_nxt  = rd_ptr_q + 1'b1;

  // Bring the asynchronous PS/2 lines into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps2c_q <= '0;
      ps2d_q <= '0;
    end else begin
      ps2c_q <= {ps2c_q[1:0], ps2_clk};
      ps2d_q <= {ps2d_q[0], ps2_data};
    end
  end

  // Frame receive FSM with inactivity timeout and registered error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          bit_cnt_q <= '0;
          tmo_q     <= '0;
          if (fall) begin
            state_q   <= S_SHIFT;
            shreg_q   <= {data_bit, shreg_q[9:1]};
            bit_cnt_q <= 4'd1;
          end
        end
        S_SHIFT: begin
          if (fall) begin
            tmo_q <= '0;
            if (bit_cnt_q == 4'd10) begin
              state_q     <= S_IDLE;
              bit_cnt_q   <= '0;
              frame_err_q <= !frame_ok;
            end else begin
              shreg_q   <= {data_bit, shreg_q[9:1]};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            // Device went quiet mid-frame: drop the partial bits silently.
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            tmo_q     <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Scancode storage array (no reset so it maps onto RAM).
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wdata;
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_nxt;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (ovf_set)          ovf_q <= 1'b1;
      else if (bus.ovf_clr) ovf_q <= 1'b0;
    end
  end

  // Registered head-of-FIFO read; bypass the write when it becomes the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
    end else if (wr_en && ((count_q == '0) || (pop && count_q == CNT_W'(1)))) begin
      head_q <= wdata;
    end else if (pop) begin
      head_q <= mem[rd_nxt];
    end
  end

  assign bus.out_valid  = (count_q != '0);
  assign bus.out_data   = head_q;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = ovf_q;
  assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: stimulus pushes expected scancodes,
// a negedge monitor pops and compares on every valid/ready handshake.
module tb_ps2_scancode_rx;
  localparam int DEPTH = 8;
  localparam int TMO   = 3000;
  localparam int CW    = 4;
  localparam int HALF  = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_scancode_rx_if #(.CNT_W(CW)) bus ();

  ps2_scancode_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int err_seen = 0;
  int err_exp = 0;
  logic ovf_exp = 1'b0;
  logic fe_prev = 1'b0;
  byte unsigned exp_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one comparison per pop, plus frame_err pulse accounting.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_err) begin
        err_seen++;
        check("frame_err width", {31'd0, fe_prev}, 32'd0);
      end
      fe_prev = bus.frame_err;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected pop: got 0x%02h, required no entry", bus.out_data);
        end else begin
          $display("pop 0x%02h", bus.out_data);
          check("pop data", {24'd0, bus.out_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end else begin
      fe_prev = 1'b0;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kind: 0 good, 1 bad parity, 2 stop=0, 3 start=1
  function automatic logic [10:0] mk_frame(byte unsigned code, int kind);
    logic [10:0] f;
    logic p;
    p = ~(^code);                      // makes the 9-bit total odd
    f = {1'b1, p, code, 1'b0};
    case (kind)
      1: f[9]  = ~f[9];
      2: f[10] = 1'b0;
      3: f[0]  = 1'b1;
      default: ;
    endcase
    return f;
  endfunction

  task automatic send_bits(logic [10:0] bits, int nbits, int half);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(half);
      ps2_clk = 1'b0;
      tick(half);
      ps2_clk = 1'b1;
    end
  endtask

  // Reference model: a good frame lands in the queue if there is room.
  task automatic send_frame(byte unsigned code, int kind);
    $display("frame code=0x%02h kind=%0d", code, kind);
    if (kind == 0) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(code);
      else ovf_exp = 1'b1;
    end else begin
      err_exp++;
    end
    send_bits(mk_frame(code, kind), 11, HALF);
    tick(4);
    check("frame_err count", err_seen, err_exp);
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, " out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, " out_data"}, {24'd0, bus.out_data}, 32'd0);
    check({tag, " fifo_count"}, {28'd0, bus.fifo_count}, 32'd0);
    check({tag, " overflow"}, {31'd0, bus.overflow}, 32'd0);
    check({tag, " frame_err"}, {31'd0, bus.frame_err}, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] f;
    bus.out_ready = 1'b0;
    bus.ovf_clr   = 1'b0;

    // Reset state, then a reset mid-frame.
    tick(3);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick(3);
    send_bits(mk_frame(8'h1C, 0), 5, HALF);
    rst_n = 1'b0;
    tick(2);
    check_idle_outputs("mid-frame reset");
    rst_n = 1'b1;
    tick(3);
    send_frame(8'h1C, 0);
    check("post-reset count", {28'd0, bus.fifo_count}, 32'd1);
    check("post-reset data", {24'd0, bus.out_data}, 32'h1C);
    pop_one();

    // Single slow frame with exact output latency.
    exp_q.push_back(8'h1C);
    f = mk_frame(8'h1C, 0);
    send_bits(f, 10, 1000);
    ps2_data = f[10];
    tick(1000);
    ps2_clk = 1'b0;
    tick(2);
    check("latency valid early", {31'd0, bus.out_valid}, 32'd0);
    tick(1);
    check("latency valid", {31'd0, bus.out_valid}, 32'd1);
    check("single data", {24'd0, bus.out_data}, 32'h1C);
    check("single count", {28'd0, bus.fifo_count}, 32'd1);
    tick(997);
    ps2_clk = 1'b1;
    tick(5);
    pop_one();
    check("single popped valid", {31'd0, bus.out_valid}, 32'd0);
    check("single popped count", {28'd0, bus.fifo_count}, 32'd0);

    // Bad parity, bad stop, bad start.
    for (int k = 1; k <= 3; k++) send_frame(8'h1C, k);
    check("errors count", {28'd0, bus.fifo_count}, 32'd0);

    // Burst into a stalled consumer: ninth frame overflows.
    for (int i = 0; i < 9; i++) send_frame((i % 2) ? 8'h1C : 8'hF0, 0);
    check("burst count", {28'd0, bus.fifo_count}, 32'd8);
    check("burst overflow", {31'd0, bus.overflow}, {31'd0, ovf_exp});
    bus.ovf_clr = 1'b1;
    tick(1);
    bus.ovf_clr = 1'b0;
    ovf_exp = 1'b0;
    check("ovf cleared", {31'd0, bus.overflow}, 32'd0);

    // Full FIFO: pop lands in the same cycle as a good frame completes.
    exp_q.push_back(8'h32);
    f = mk_frame(8'h32, 0);
    send_bits(f, 10, HALF);
    ps2_data = f[10];
    tick(HALF);
    ps2_clk = 1'b0;
    tick(2);
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    check("simul count", {28'd0, bus.fifo_count}, 32'd8);
    check("simul overflow", {31'd0, bus.overflow}, 32'd0);
    tick(HALF);
    ps2_clk = 1'b1;
    tick(HALF);

    // Drain; monitor verifies order with 0x32 last.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    check("drain empty", exp_q.size(), 32'd0);
    check("drain count", {28'd0, bus.fifo_count}, 32'd0);
    bus.out_ready = 1'b0;

    // Abandoned partial frame followed by a clean one.
    send_bits(mk_frame(8'h45, 0), 4, HALF);
    tick(TMO + 20);
    send_frame(8'h45, 0);
    check("timeout count", {28'd0, bus.fifo_count}, 32'd1);
    check("timeout data", {24'd0, bus.out_data}, 32'h45);
    pop_one();
    tick(2);
    check("timeout empty", {28'd0, bus.fifo_count}, 32'd0);

    // Wrap-around: 20 push/pop pairs with streaming consumer.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send_frame(8'($urandom_range(0, 255)), 0);

    // Random codes with random frame corruption.
    for (int i = 0; i < 30; i++) begin
      int kind;
      kind = $urandom_range(0, 7);
      if (kind > 3) kind = 0;
      send_frame(8'($urandom_range(0, 255)), kind);
    end
    tick(10);
    check("final queue empty", exp_q.size(), 32'd0);
    check("final count", {28'd0, bus.fifo_count}, 32'd0);
    check("final overflow", {31'd0, bus.overflow}, {31'd0, ovf_exp});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
PS/2 keyboard receiver that deserialises device-clocked 11-bit frames into 8-bit scancodes and buffers them in a small FIFO. It is the upstream stage of the keyed lookup mux. Its head-of-FIFO scancode drives the mux key input for scancode-to-ASCII/segment decoding. Consumers pop codes with a valid/ready handshake.

Parameters:
FIFO_DEPTH, 8, number of buffered scancodes; power of two, >= 2
TIMEOUT_CYC, 50000, clk cycles without a PS/2 falling edge before a partial frame is abandoned
CNT_W, 4, width of fifo_count; equals log2(FIFO_DEPTH)+1

Ports:
clk  input  1  system clock; the block's only clock
rst_n  input  1  asynchronous active-low reset
ps2_clk  input  1  raw PS/2 clock from device, asynchronous
ps2_data  input  1  raw PS/2 data, asynchronous
out_ready  input  1  consumer accepts head entry this cycle
ovf_clr  input  1  clears sticky overflow flag
out_valid  output  1  FIFO non-empty
out_data  output  8  head scancode (key input of downstream mux)
fifo_count  output  CNT_W  entries held, 0..FIFO_DEPTH
overflow  output  1  sticky: a good frame was dropped because FIFO was full
frame_err  output  1  one-cycle pulse: completed frame failed start/stop/parity check

Behaviour:
- Reset (async assert, sync-released use): all flops cleared. out_valid=0, out_data=0, fifo_count=0, overflow=0, frame_err=0. bit counter=0, timeout counter=0. FIFO pointers=0. Reset mid-frame discards partial bits.
- Synchronisation: ps2_clk passes through a 3-flop chain s[2:0]. A falling edge is detected when s[2:1]==2'b10. ps2_data passes through a 2-flop chain and is sampled in the edge-detect cycle.
- Receive FSM states:
  - IDLE: bit_cnt=0.
  - IDLE -> SHIFT on the first falling edge; that bit is taken as the start bit.
  - SHIFT: each falling edge shifts the data bit into a 10-bit register, LSB first, and increments bit_cnt.
  - On the 11th edge (bit_cnt==10), frame check is evaluated combinationally on the register plus the incoming stop bit:
    - start==0
    - stop==1
    - XOR(data[7:0], parity)==1 (odd parity)
  - SHIFT -> IDLE after the 11th edge, regardless of check result.
- Frame pass: FIFO write on that clk edge. out_valid visible the next cycle, i.e. 1 cycle after the 11th edge is detected.
- Frame fail: no write. frame_err pulses high for exactly that one cycle.
- Timeout: in SHIFT, a counter increments every clk and resets on each detected edge. Reaching TIMEOUT_CYC-1 returns to IDLE, bit_cnt=0, frame discarded, no frame_err. The counter is held at 0 in IDLE.
- FIFO:
  - Circular buffer with rd/wr pointers of width log2(FIFO_DEPTH) that wrap naturally; count tracked separately.
  - out_data = mem[rd_ptr], registered memory read without extra latency (show-ahead).
  - Pop occurs when out_valid && out_ready. out_ready while empty is ignored.
  - Push of a good frame:
    - Accepted if count<FIFO_DEPTH.
    - Also accepted when full if a pop occurs in the same cycle; count is unchanged in that case.
    - Otherwise the frame is dropped and overflow is set.
  - Simultaneous push+pop when not full or empty: count unchanged, both pointers advance.
  - Push into empty FIFO with out_ready high: the entry is not popped that cycle, since out_valid was 0.
- overflow: sticky until ovf_clr. If ovf_clr and a new overflow occur in the same cycle, set wins.
- fifo_count equals the number of valid entries at all times.

Test Plan:
- Reset: hold rst_n=0 mid-frame after 5 edges, release -> all outputs 0. Next full 0x1C frame received correctly; no corruption from the partial frame.
- Single frame: bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1 (code 0x1C), ps2_clk period 2000 clk -> out_valid=1, out_data=0x1C, fifo_count=1 one cycle after the 11th edge. Pulse out_ready -> out_valid=0, count=0.
- Errors: 0x1C frame with parity=1 -> frame_err one-cycle pulse, count stays 0. Frame with stop=0 -> same. Frame with start=1 -> same.
- Burst/full: out_ready=0, send 0xF0,0x1C repeated to 9 frames -> count=8, overflow=1. Drain order is 0xF0,0x1C,... (first 8 frames). ovf_clr -> overflow=0.
- Simultaneous: FIFO full, out_ready=1 in the cycle a good 0x32 frame completes -> count stays 8, overflow stays 0, 0x32 appears as the last entry.
- Timeout: send 4 edges, then idle for TIMEOUT_CYC cycles, then a full 0x45 frame -> exactly one entry 0x45, no frame_err. Also run a wrap-around test of 20 push/pop pairs with data matching in order.
